// File: rtl/text_console_ctrl.sv
// Write-side controller for the character RAM: consumes console bytes, tracks the
// cursor, drives write strobes and implements hardware scroll plus full clear.
module text_console_ctrl #(
    parameter int          COLS       = 40,
    parameter int          ROWS       = 32,
    parameter int          ADDR_WIDTH = 11,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic                  in_main_clock,
    input  logic                  in_reset_n,
    input  logic                  in_char_valid,
    input  logic [7:0]            in_char,
    output logic                  out_char_ready,
    input  logic                  in_clear,
    output logic                  out_busy,
    output logic [ADDR_WIDTH-1:0] out_ram_wr_address,
    output logic [7:0]            out_ram_wr_data,
    output logic                  out_ram_wr_enable,
    output logic [5:0]            out_cursor_x,
    output logic [4:0]            out_cursor_y,
    output logic [4:0]            out_top_row
);

    localparam logic [ADDR_WIDTH-1:0] LP_COLS  = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LP_CELLS = ADDR_WIDTH'(COLS * ROWS);
    localparam logic [5:0]            LP_XMAX  = 6'(COLS - 1);
    localparam logic [4:0]            LP_YMAX  = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;

    state_t                  r_state;
    logic [5:0]              r_x;
    logic [4:0]              r_y;
    logic [4:0]              r_top;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [7:0]              r_data;
    logic                    r_wr_en;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_clr_pend;
    logic                    r_scroll_pend;

    logic [5:0]              w_row_sum;
    logic [4:0]              w_row;
    logic [ADDR_WIDTH-1:0]   w_row_base;
    logic [ADDR_WIDTH-1:0]   w_cur_addr;
    logic [ADDR_WIDTH-1:0]   w_bs_addr;
    logic [ADDR_WIDTH-1:0]   w_top_base;
    logic [4:0]              w_top_next;
    logic                    w_clear_req;
    logic                    w_accept;
    logic                    w_printable;

    // Logical row is rotated by the scroll offset to get the physical row.
    assign w_row_sum   = {1'b0, r_top} + {1'b0, r_y};
    assign w_row       = (w_row_sum >= 6'(ROWS)) ? 5'(w_row_sum - 6'(ROWS)) : w_row_sum[4:0];
    assign w_row_base  = ADDR_WIDTH'(w_row) * LP_COLS;
    assign w_cur_addr  = w_row_base + ADDR_WIDTH'(r_x);
    assign w_bs_addr   = w_row_base + ADDR_WIDTH'(r_x - 6'd1);
    assign w_top_base  = ADDR_WIDTH'(r_top) * LP_COLS;
    assign w_top_next  = (r_top == LP_YMAX) ? 5'd0 : r_top + 5'd1;
    assign w_clear_req = in_clear | r_clr_pend;
    assign w_accept    = r_ready & in_char_valid & ~w_clear_req;
    assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

    // A clear seen in the same cycle as a ready byte wins; the byte is left for later.
    always_ff @(posedge in_main_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_top         <= '0;
            r_addr        <= '0;
            r_base        <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_wr_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b0;
            r_clr_pend    <= 1'b0;
            r_scroll_pend <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clear_req) begin
                        r_state    <= CLR_ALL;
                        r_addr     <= '0;
                        r_cnt      <= ADDR_WIDTH'(1);
                        r_data     <= FILL_CHAR;
                        r_wr_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_clr_pend <= 1'b0;
                    end else if (w_accept) begin
                        if (w_printable) begin
                            r_state <= WRITE;
                            r_addr  <= w_cur_addr;
                            r_data  <= in_char;
                            r_wr_en <= 1'b1;
                            if (r_x == LP_XMAX) begin
                                r_x <= '0;
                                if (r_y == LP_YMAX) r_scroll_pend <= 1'b1;
                                else                r_y <= r_y + 5'd1;
                            end else begin
                                r_x <= r_x + 6'd1;
                            end
                        end else begin
                            case (in_char)
                                8'h0D: begin
                                    r_x     <= '0;
                                    r_ready <= 1'b1;
                                end
                                8'h0A: begin
                                    if (r_y == LP_YMAX) begin
                                        r_state <= CLR_LINE;
                                        r_top   <= w_top_next;
                                        r_base  <= w_top_base;
                                        r_addr  <= w_top_base;
                                        r_cnt   <= ADDR_WIDTH'(1);
                                        r_data  <= FILL_CHAR;
                                        r_wr_en <= 1'b1;
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_y     <= r_y + 5'd1;
                                        r_ready <= 1'b1;
                                    end
                                end
                                8'h08: begin
                                    if (r_x != 6'd0) begin
                                        r_state <= WRITE;
                                        r_x     <= r_x - 6'd1;
                                        r_addr  <= w_bs_addr;
                                        r_data  <= FILL_CHAR;
                                        r_wr_en <= 1'b1;
                                    end else begin
                                        r_ready <= 1'b1;
                                    end
                                end
                                8'h0C: begin
                                    r_state <= CLR_ALL;
                                    r_addr  <= '0;
                                    r_cnt   <= ADDR_WIDTH'(1);
                                    r_data  <= FILL_CHAR;
                                    r_wr_en <= 1'b1;
                                    r_busy  <= 1'b1;
                                end
                                default: r_ready <= 1'b1;
                            endcase
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                // A pending clear supersedes a pending scroll since it wipes everything.
                WRITE: begin
                    r_scroll_pend <= 1'b0;
                    if (w_clear_req) begin
                        r_state    <= CLR_ALL;
                        r_addr     <= '0;
                        r_cnt      <= ADDR_WIDTH'(1);
                        r_data     <= FILL_CHAR;
                        r_wr_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_clr_pend <= 1'b0;
                    end else if (r_scroll_pend) begin
                        r_state <= CLR_LINE;
                        r_top   <= w_top_next;
                        r_base  <= w_top_base;
                        r_addr  <= w_top_base;
                        r_cnt   <= ADDR_WIDTH'(1);
                        r_data  <= FILL_CHAR;
                        r_wr_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end

                CLR_LINE: begin
                    if (in_clear) r_clr_pend <= 1'b1;
                    if (r_cnt < LP_COLS) begin
                        r_addr  <= r_base + r_cnt;
                        r_cnt   <= r_cnt + ADDR_WIDTH'(1);
                        r_wr_en <= 1'b1;
                    end else if (w_clear_req) begin
                        r_state    <= CLR_ALL;
                        r_addr     <= '0;
                        r_cnt      <= ADDR_WIDTH'(1);
                        r_data     <= FILL_CHAR;
                        r_wr_en    <= 1'b1;
                        r_clr_pend <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end

                CLR_ALL: begin
                    if (r_cnt < LP_CELLS) begin
                        r_addr  <= r_cnt;
                        r_cnt   <= r_cnt + ADDR_WIDTH'(1);
                        r_wr_en <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_top   <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= ~in_clear;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_char_ready     = r_ready;
    assign out_busy           = r_busy;
    assign out_ram_wr_address = r_addr;
    assign out_ram_wr_data    = r_data;
    assign out_ram_wr_enable  = r_wr_en;
    assign out_cursor_x       = r_x;
    assign out_cursor_y       = r_y;
    assign out_top_row        = r_top;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a screen-level model predicts every RAM strobe and the
// cursor/scroll state; directed byte sequences exercise scroll, clear and reset.
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  ch = 8'h00;
    logic        clr = 1'b0;
    logic        ready;
    logic        busy;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic        wen;
    logic [5:0]  cx;
    logic [4:0]  cy;
    logic [4:0]  top;

    int          checks = 0;
    int          passed = 0;
    int          mX = 0;
    int          mY = 0;
    int          mTop = 0;
    logic [18:0] expQ[$];

    text_console_ctrl dut (
        .in_main_clock      (clk),
        .in_reset_n         (rst_n),
        .in_char_valid      (valid),
        .in_char            (ch),
        .out_char_ready     (ready),
        .in_clear           (clr),
        .out_busy           (busy),
        .out_ram_wr_address (waddr),
        .out_ram_wr_data    (wdata),
        .out_ram_wr_enable  (wen),
        .out_cursor_x       (cx),
        .out_cursor_y       (cy),
        .out_top_row        (top)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int physAddr(input int x, input int y);
        return ((mTop + y) % 32) * 40 + x;
    endfunction

    // Screen model: writes are queued in the order the console must produce them.
    task automatic modelNewline();
        int oldTop;
        if (mY < 31) begin
            mY++;
        end else begin
            oldTop = mTop;
            mTop = (mTop + 1) % 32;
            for (int c = 0; c < 40; c++) expQ.push_back({11'(oldTop * 40 + c), 8'h20});
        end
    endtask

    task automatic modelClear();
        for (int a = 0; a < 1280; a++) expQ.push_back({11'(a), 8'h20});
        mX = 0;
        mY = 0;
        mTop = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            expQ.push_back({11'(physAddr(mX, mY)), b});
            if (mX == 39) begin
                mX = 0;
                modelNewline();
            end else begin
                mX++;
            end
        end else if (b == 8'h0D) begin
            mX = 0;
        end else if (b == 8'h0A) begin
            modelNewline();
        end else if (b == 8'h08) begin
            if (mX > 0) begin
                mX--;
                expQ.push_back({11'(physAddr(mX, mY)), 8'h20});
            end
        end else if (b == 8'h0C) begin
            modelClear();
        end
    endtask

    // Every strobe is matched against the next predicted write.
    always @(negedge clk) begin
        logic [18:0] e;
        if (rst_n && wen) begin
            checkOutput("addr_in_range", int'(waddr < 11'd1280), 1);
            checkOutput("ready_during_strobe", int'(ready), 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe_addr", int'(waddr), -1);
            end else begin
                e = expQ.pop_front();
                checkOutput("strobe_addr", int'(waddr), int'(e[18:8]));
                checkOutput("strobe_data", int'(wdata), int'(e[7:0]));
            end
        end
    end

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                return;
            end
        end
        checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bit ok;
        waitReady(ok);
        if (!ok) return;
        valid = 1'b1;
        ch    = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        modelByte(b);
    endtask

    task automatic waitIdle();
        bit ok;
        waitReady(ok);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("cursor_x", int'(cx), mX);
        checkOutput("cursor_y", int'(cy), mY);
        checkOutput("top_row", int'(top), mTop);
        checkOutput("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCnt;
        bit readySeen;

        #12;
        checkOutput("rst_wen", int'(wen), 0);
        checkOutput("rst_ready", int'(ready), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_addr", int'(waddr), 0);
        checkOutput("rst_cx", int'(cx), 0);
        checkOutput("rst_top", int'(top), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single printable character.
        applyStimulus(8'h41);
        @(negedge clk);
        checkOutput("t1_wen", int'(wen), 1);
        checkOutput("t1_addr", int'(waddr), 0);
        checkOutput("t1_data", int'(wdata), 8'h41);
        checkOutput("t1_ready_low", int'(ready), 0);
        @(negedge clk);
        checkOutput("t1_ready_back", int'(ready), 1);
        checkOutput("t1_wen_off", int'(wen), 0);
        checkOutput("t1_cx", int'(cx), 1);
        checkOutput("t1_cy", int'(cy), 0);

        // Full line with wrap.
        applyStimulus(8'h0D);
        for (int i = 0; i < 40; i++) applyStimulus(8'h42);
        waitIdle();
        checkOutput("t2_cx", int'(cx), 0);
        checkOutput("t2_cy", int'(cy), 1);

        // Walk to the bottom row, then scroll once.
        for (int i = 0; i < 30; i++) applyStimulus(8'h0A);
        waitIdle();
        applyStimulus(8'h0A);
        busyCnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            busyCnt++;
        end
        checkOutput("t3_busy_cycles", busyCnt, 40);
        checkOutput("t3_top", int'(top), 1);
        checkOutput("t3_cx", int'(cx), 0);
        checkOutput("t3_cy", int'(cy), 31);
        applyStimulus(8'h43);
        @(negedge clk);
        checkOutput("t3_after_scroll_addr", int'(waddr), 0);
        checkOutput("t3_after_scroll_data", int'(wdata), 8'h43);
        waitIdle();

        // Scroll a full lap so the offset wraps.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'h0A);
            waitIdle();
            if (i == 30) checkOutput("t4_top_wrapped", int'(top), 0);
        end
        checkOutput("t4_top_final", int'(top), 1);

        // Clear requested during a line clear, with a byte held waiting.
        applyStimulus(8'h0A);
        modelClear();
        valid = 1'b1;
        ch    = 8'h44;
        busyCnt = 0;
        readySeen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 5) clr = 1'b1;
            if (i == 6) clr = 1'b0;
            if (ready) begin
                readySeen = 1'b1;
                break;
            end
            if (busy) busyCnt++;
        end
        checkOutput("t5_ready_seen", int'(readySeen), 1);
        checkOutput("t5_busy_cycles", busyCnt, 1320);
        checkOutput("t5_cx", int'(cx), 0);
        checkOutput("t5_cy", int'(cy), 0);
        checkOutput("t5_top", int'(top), 0);
        checkOutput("t5_queue", expQ.size(), 0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        modelByte(8'h44);
        @(negedge clk);
        checkOutput("t5_byte_wen", int'(wen), 1);
        checkOutput("t5_byte_addr", int'(waddr), 0);
        checkOutput("t5_byte_data", int'(wdata), 8'h44);
        waitIdle();

        // Backspace at column 0 and at column 5.
        applyStimulus(8'h0D);
        applyStimulus(8'h08);
        repeat (3) @(negedge clk);
        waitIdle();
        checkOutput("t6_bs0_cx", int'(cx), 0);
        for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i));
        applyStimulus(8'h08);
        @(negedge clk);
        checkOutput("t6_bs_addr", int'(waddr), 4);
        checkOutput("t6_bs_data", int'(wdata), 8'h20);
        waitIdle();
        checkOutput("t6_bs_cx", int'(cx), 4);

        // Form feed starts a full clear; reset lands in the middle of it.
        applyStimulus(8'h0C);
        repeat (100) @(negedge clk);
        checkOutput("t6_busy_before_reset", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_wen", int'(wen), 0);
        checkOutput("t6_rst_busy", int'(busy), 0);
        checkOutput("t6_rst_ready", int'(ready), 0);
        checkOutput("t6_rst_addr", int'(waddr), 0);
        checkOutput("t6_rst_data", int'(wdata), 0);
        checkOutput("t6_rst_cx", int'(cx), 0);
        checkOutput("t6_rst_cy", int'(cy), 0);
        checkOutput("t6_rst_top", int'(top), 0);
        expQ.delete();
        mX = 0;
        mY = 0;
        mTop = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        waitIdle();
        applyStimulus(8'h45);
        waitIdle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
